load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the core's memory pipeline stage and Mem_Datos (word-wide data memory: combinational read of mem[Address], write on rising CLK when Write_EN=1).
- Converts RISC-V byte, halfword and word loads and stores into word accesses.
- Sub-word stores are done as a read-modify-write; load results are sign- or zero-extended.
- Flags misaligned, illegal or out-of-range requests without touching memory.

Parameters:
- DEPTH, 256, number of 32-bit words in Mem_Datos; valid word index range is 0..DEPTH-1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word is taken from the LSBs.
- resp_valid  out  1  one-cycle pulse that completes each accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal funct3 or out of range; qualified by resp_valid.
- Address  out  32  word index to Mem_Datos (req_addr>>2).
- WriteData  out  32  merged word to Mem_Datos.
- Write_EN  out  1  Mem_Datos write enable.
- Read_Data  in  32  word from Mem_Datos.

Behaviour:
- State machine states: IDLE, RD, WR, RESP.
- req_ready = (state==IDLE). A request is accepted when req_valid && req_ready. On acceptance, addr, we, funct3 and wdata are latched.
- Error check at accept (decided combinationally):
  - misaligned: H/HU with addr[0]≠0, or W with addr[1:0]≠0;
  - illegal funct3: 011/110/111, or a store with 100/101;
  - out of range: addr>>2 ≥ DEPTH.
  - On error: IDLE→RESP with resp_err=1, resp_rdata=0. No RD or WR state is entered and Write_EN never rises.
- Transitions for legal requests:
  - load: IDLE→RD→RESP;
  - SW: IDLE→WR→RESP;
  - SB/SH: IDLE→RD→WR→RESP;
  - RESP→IDLE always.
- Address is registered at accept and held constant through RD and WR.
- RD: Read_Data is captured into rd_buf at the end of the cycle.
- Write_EN = (state==WR), exactly one cycle per store.
- WriteData in WR:
  - SW: the latched wdata.
  - SB at byte offset k: rd_buf with bits [8k+7:8k] replaced by wdata[7:0].
  - SH at offset 0 or 2: half [15:0] or [31:16] replaced by wdata[15:0].
- Load extraction from rd_buf:
  - byte at offset k, halfword at offset 0/2;
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
- Latency, counting the accept edge as cycle N:
  - load and SW: resp_valid during cycle N+2;
  - SB/SH: N+3;
  - error: N+1.
  - Throughput is one request in flight at a time.
- resp_rdata and resp_err are registered. They are valid only while resp_valid=1 and are cleared to 0 in every other cycle.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, Address=0, WriteData=0, Write_EN=0, rd_buf=0.
- Reset mid-operation: the next edge returns to IDLE. An in-flight request is dropped: no response is produced and no write is performed. If RST is sampled during WR, Write_EN is low from that edge onward; a write on that same edge still occurs in Mem_Datos, which is acceptable.
- req_valid while not ready is ignored. The core must hold the request until it is accepted.

Decomposition:
- Shared package rv_mem_pkg:
  - funct3 constants F3_B/H/W/BU/HU;
  - state encodings IDLE/RD/WR/RESP;
  - widths XLEN=32.
- One combinational sub-module lsu_align. Inputs: funct3, addr[1:0], rd_word, wdata. Outputs: merged store word, extended load word, misalign flag.
- The FSM and registers stay in load_store_unit.

Test Plan:
1. SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 → Address=4, Write_EN high exactly one cycle; load resp_rdata=0xDEADBEEF at accept+2, resp_err=0.
2. With word 4 = 0xDEADBEEF: SB addr 0x11 wdata 0x55, then LW 0x10 → word becomes 0xDEAD55EF; LB 0x13 → 0xFFFFFFDE, LBU 0x13 → 0x000000DE.
3. SH addr 0x12 wdata 0x8001, then LH 0x12 → 0xFFFF8001, LHU → 0x00008001; lower half unchanged at 0x55EF.
4. Errors: LW addr 0x13; SH addr 0x11; funct3 011; addr 0x400 with DEPTH=256 → resp_valid at accept+1 with resp_err=1, resp_rdata=0, Write_EN never high, memory unchanged.
5. Assert RST during the RD state of an SB → no resp_valid, no Write_EN pulse, req_ready=1 the cycle after reset, and a following LW returns the old data.
6. Back-to-back requests with req_valid held high → each request accepted only in IDLE; req_ready=0 during RD/WR/RESP; exactly one resp_valid per request, delivered in order.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the load/store path: funct3 encodings, FSM states and widths.
package rv_mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Unsigned variants only make sense for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        f3_legal = ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: merges sub-word store data into a word and extracts/extends load data.
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rd_word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] store_word,
    output logic [XLEN-1:0] load_word,
    output logic            misalign
);

    logic [4:0]  bit_off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign bit_off  = {addr_lo, 3'b000};
    assign sel_byte = rd_word[bit_off +: 8];
    assign sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_word  = '0;
        store_word = rd_word;
        misalign   = 1'b0;
        case (funct3)
            F3_B: begin
                load_word                 = {{24{sel_byte[7]}}, sel_byte};
                store_word[bit_off +: 8]  = wdata[7:0];
            end
            F3_BU: begin
                load_word = {24'b0, sel_byte};
            end
            F3_H: begin
                load_word = {{16{sel_half[15]}}, sel_half};
                misalign  = addr_lo[0];
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            F3_HU: begin
                load_word = {16'b0, sel_half};
                misalign  = addr_lo[0];
            end
            F3_W: begin
                load_word  = rd_word;
                store_word = wdata;
                misalign   = |addr_lo;
            end
            default: begin
                load_word  = '0;
                store_word = rd_word;
                misalign   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V B/H/W loads and stores into word accesses on Mem_Datos.
//
//   state | meaning
//   IDLE  | ready; request accepted and checked here
//   RD    | Address presented, Read_Data captured into rd_buf
//   WR    | Write_EN high for one cycle with merged WriteData
//   RESP  | resp_valid pulse with registered rdata/err
module load_store_unit
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] Address,
    output logic [XLEN-1:0] WriteData,
    output logic            Write_EN,
    input  logic [XLEN-1:0] Read_Data
);

    lsu_state_t      state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rd_buf;

    logic            idle;
    logic            accept;
    logic [2:0]      al_funct3;
    logic [1:0]      al_addr_lo;
    logic [XLEN-1:0] al_rd_word;
    logic [XLEN-1:0] al_wdata;
    logic [XLEN-1:0] store_word;
    logic [XLEN-1:0] load_word;
    logic            misalign;
    logic            illegal;
    logic            out_of_range;
    logic            req_err;

    assign idle      = (state == IDLE);
    assign req_ready = idle;
    assign accept    = req_valid && idle;

    // The aligner is shared: in IDLE it looks at the incoming request (misalign
    // check, SW data); afterwards at the latched request. In RD it sees Read_Data
    // directly so merge/extract results can be registered on the RD exit edge.
    assign al_funct3  = idle ? req_funct3 : f3_q;
    assign al_addr_lo = idle ? req_addr[1:0] : addr_lo_q;
    assign al_wdata   = idle ? req_wdata : wdata_q;
    assign al_rd_word = (state == RD) ? Read_Data : rd_buf;

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .rd_word    (al_rd_word),
        .wdata      (al_wdata),
        .store_word (store_word),
        .load_word  (load_word),
        .misalign   (misalign)
    );

    assign illegal      = !f3_legal(req_funct3, req_we);
    assign out_of_range = (req_addr >> 2) >= 32'(DEPTH);
    assign req_err      = misalign || illegal || out_of_range;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            rd_buf     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            Address    <= '0;
            WriteData  <= '0;
            Write_EN   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            Write_EN   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        Address   <= {2'b00, req_addr[31:2]};
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            state     <= WR;
                            Write_EN  <= 1'b1;
                            WriteData <= store_word;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    rd_buf <= Read_Data;
                    if (we_q) begin
                        state     <= WR;
                        Write_EN  <= 1'b1;
                        WriteData <= store_word;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_word;
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
